// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX-to-MEM bus, extracts and
// extends load data from the synchronous data SRAM and drives the WB and
// ID-forwarding buses. A one-entry buffer keeps load data stable under stall.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [89:0] ex_to_mem_bus,
    input  logic [31:0] data_sram_rdata,
    output logic [69:0] mem_to_wb_bus,
    output logic [37:0] mem_to_id_bus
);

    localparam int unsigned ExToMemWd = 90;

    logic [ExToMemWd-1:0] r;
    logic [31:0]          hold_data;
    logic                 hold_vld;

    // Decoded pipeline register fields
    logic [13:0] sl_bus;
    logic [31:0] ex_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        ld_w, st_w, ld_b, ld_bu, ld_h, ld_hu, st_b, st_h;

    logic [31:0] rd;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    assign {sl_bus, ex_pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr,
            ex_result} = r;
    assign {ld_w, st_w, ld_b, ld_bu, ld_h, ld_hu, st_b, st_h} = sl_bus[13:6];

    // Store flags and SRAM controls were consumed in EX; MEM ignores them
    logic unused_fields;
    assign unused_fields = ^{sl_bus[5:0], st_w, st_b, st_h, data_ram_en, data_ram_wen};

    // Pipeline register: reset, bubble on stall-from-MEM-only, load, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (stall[3] && !stall[4]) begin
            r <= '0;
        end else if (!stall[3]) begin
            r <= ex_to_mem_bus;
        end
    end

    // Read-data hold buffer: capture SRAM word on the first stalled edge of MEM
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (!stall[3] || !stall[4]) begin
            // New instruction or bubble enters MEM: any held word is stale
            hold_vld <= 1'b0;
        end else if (!hold_vld) begin
            hold_vld  <= 1'b1;
            hold_data <= data_sram_rdata;
        end
    end

    // Load extraction, write-data select and output bus assembly
    always_comb begin
        rd       = hold_vld ? hold_data : data_sram_rdata;
        byte_sel = 8'h00;
        unique case (ex_result[1:0])
            2'd0: byte_sel = rd[7:0];
            2'd1: byte_sel = rd[15:8];
            2'd2: byte_sel = rd[23:16];
            2'd3: byte_sel = rd[31:24];
            default: byte_sel = 8'h00;
        endcase
        // Halfword offset ignores a[0]; misalignment is not flagged here
        half_sel = ex_result[1] ? rd[31:16] : rd[15:0];

        load_data = rd;
        if (ld_w) begin
            load_data = rd;
        end else if (ld_b) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_bu) begin
            load_data = {24'h000000, byte_sel};
        end else if (ld_h) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (ld_hu) begin
            load_data = {16'h0000, half_sel};
        end

        rf_wdata      = sel_rf_res ? load_data : ex_result;
        mem_to_wb_bus = {ex_pc, rf_we, rf_waddr, rf_wdata};
        mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};
    end

endmodule
